// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-machine button path.
// The event encoding is also consumed by the vending controller.
package vend_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM1 = 2'd1,
      ARM2 = 2'd2,
      HELD = 2'd3
   } vend_btn_state_t;

   typedef enum logic [1:0] {
      EV_NONE     = 2'd0,
      EV_SELECT   = 2'd1,
      EV_DISPENSE = 2'd2,
      EV_CLEAR    = 2'd3
   } vend_event_t;

   localparam logic BTN_PRESSED_N = 1'b0;

endpackage

// File: rtl/vend_btn_debounce.sv
// Two-flop synchroniser and saturating debounce counter for one active-low button.
// level is the debounced, active-high button state.
module vend_btn_debounce
   import vend_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_n,
   output logic level
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          level_q, level_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // The counter only runs while the synchronised input disagrees with the level.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = ~level_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= (btn_n == BTN_PRESSED_N);
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = level_q;

endmodule

// File: rtl/vend_button_conditioner.sv
// Debounces both buttons and resolves single presses, long holds and two-button
// chords into mutually exclusive one-cycle select/dispense/clear pulses.
module vend_button_conditioner
   import vend_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CHORD_CYCLES    = 2500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn1_n,
   input  logic btn2_n,
   output logic sel_pulse,
   output logic disp_pulse,
   output logic clear_pulse,
   output logic btn1_level,
   output logic btn2_level
);

   localparam int TW = $clog2(CHORD_CYCLES);
   localparam logic [TW-1:0] TIMER_LAST = TW'(CHORD_CYCLES - 1);

   logic            lvl1, lvl2;
   logic            lvl1_prev_q, lvl2_prev_q;
   logic            rise1, rise2;
   vend_btn_state_t state_q, state_d;
   logic [TW-1:0]   timer_q, timer_d;
   vend_event_t     ev_d;
   logic            sel_q, disp_q, clear_q;

   vend_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb1 (
      .clk   (clk),
      .rst_n (rst_n),
      .btn_n (btn1_n),
      .level (lvl1)
   );

   vend_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb2 (
      .clk   (clk),
      .rst_n (rst_n),
      .btn_n (btn2_n),
      .level (lvl2)
   );

   assign rise1 = lvl1 & ~lvl1_prev_q;
   assign rise2 = lvl2 & ~lvl2_prev_q;

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      ev_d    = EV_NONE;
      case (state_q)
         IDLE: begin
            timer_d = '0;
            if (rise1 && rise2) begin
               ev_d    = EV_CLEAR;
               state_d = HELD;
            end else if (rise1) begin
               state_d = ARM1;
            end else if (rise2) begin
               state_d = ARM2;
            end
         end
         ARM1: begin
            timer_d = timer_q + 1'b1;
            if (lvl2) begin
               ev_d    = EV_CLEAR;
               state_d = HELD;
            end else if (!lvl1) begin
               ev_d    = EV_SELECT;
               state_d = IDLE;
            end else if (timer_q == TIMER_LAST) begin
               ev_d    = EV_SELECT;
               state_d = HELD;
            end
         end
         ARM2: begin
            timer_d = timer_q + 1'b1;
            if (lvl1) begin
               ev_d    = EV_CLEAR;
               state_d = HELD;
            end else if (!lvl2) begin
               ev_d    = EV_DISPENSE;
               state_d = IDLE;
            end else if (timer_q == TIMER_LAST) begin
               ev_d    = EV_DISPENSE;
               state_d = HELD;
            end
         end
         HELD: begin
            // Late second presses are swallowed here; only a full release re-arms.
            if (!lvl1 && !lvl2) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         timer_q     <= '0;
         lvl1_prev_q <= 1'b0;
         lvl2_prev_q <= 1'b0;
         sel_q       <= 1'b0;
         disp_q      <= 1'b0;
         clear_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         lvl1_prev_q <= lvl1;
         lvl2_prev_q <= lvl2;
         sel_q       <= (ev_d == EV_SELECT);
         disp_q      <= (ev_d == EV_DISPENSE);
         clear_q     <= (ev_d == EV_CLEAR);
      end
   end

   assign sel_pulse   = sel_q;
   assign disp_pulse  = disp_q;
   assign clear_pulse = clear_q;
   assign btn1_level  = lvl1;
   assign btn2_level  = lvl2;

endmodule
